bc_guess_entry: RTL and testbench

Upstream input stage of the Bulls & Cows game controller. It synchronises and debounces the raw confirm push-button, and captures the 16-bit switch word (four BCD digits, one per nibble) when a press is detected. It then validates the captured word: each digit must be 0–9 and all four digits must be distinct. A valid word is offered to the game FSM through a valid/ready handshake. An invalid word is never offered; the block raises a sticky error flag instead.

---
 rtl/bc_pkg.sv | 36 +++
 rtl/bc_debounce.sv | 83 ++++++++
 rtl/bc_guess_entry.sv | 99 +++++++++
 tb/tb_bc_guess_entry.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared types, constants and digit validity check for the Bulls & Cows controller
package bc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CHECK        = 2'd1,
        ST_OFFER        = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } entry_state_t;

    // A word is a legal guess when every nibble is a decimal digit and no digit repeats.
    function automatic logic digits_valid(input logic [15:0] word);
        logic [DIGIT_W-1:0] dig [NUM_DIGITS];
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig[i] = word[i*DIGIT_W +: DIGIT_W];
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig[i] > DIGIT_MAX) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (dig[i] == dig[j]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bc_debounce.sv
// rtl/bc_debounce.sv - button synchroniser, debouncer and rising-edge pulse generator
module bc_debounce
    import bc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sync1_q, sync2_q;
    logic [1:0] prime_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic clean_q, clean_d;
    logic rise_q, rise_d;
    logic armed_q, armed_d;

    // Accept a level change only after it has persisted for DEBOUNCE_CYCLES samples.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            clean_d = sync2_q;
            cnt_d   = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // A button held through reset must be seen released before its next press counts.
    // prime_q masks the reset values still flowing through the synchroniser.
    always_comb begin
        low_cnt_d = low_cnt_q;
        armed_d   = armed_q;
        if (!prime_q[1] || sync2_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q >= CNT_LAST) begin
            low_cnt_d = CNT_MAX;
            armed_d   = 1'b1;
        end else begin
            low_cnt_d = low_cnt_q + CNT_ONE;
        end
        rise_d = clean_d & ~clean_q & armed_q;
    end

    // Synchroniser, debounce and edge-detect state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prime_q   <= 2'b00;
            cnt_q     <= '0;
            low_cnt_q <= '0;
            clean_q   <= 1'b0;
            rise_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            prime_q   <= {prime_q[0], 1'b1};
            cnt_q     <= cnt_d;
            low_cnt_q <= low_cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            armed_q   <= armed_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;

endmodule

// File: rtl/bc_guess_entry.sv
// rtl/bc_guess_entry.sv - captures, validates and offers a four-digit guess on each button press
module bc_guess_entry
    import bc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] guess_out,
    output logic        guess_valid,
    input  logic        guess_ready,
    output logic        error
);

    logic btn_clean;
    logic btn_rise;

    entry_state_t state_q, state_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] guess_q, guess_d;
    logic valid_q, valid_d;
    logic error_q, error_d;

    bc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .raw(btn),
        .clean(btn_clean),
        .rise(btn_rise)
    );

    // Entry FSM: one capture per press, one offer per valid capture.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        guess_d = guess_q;
        valid_d = valid_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rise) begin
                    cap_d   = sw;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (digits_valid(cap_q)) begin
                    guess_d = cap_q;
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    state_d = ST_OFFER;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_OFFER: begin
                if (valid_q && guess_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!btn_clean) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, capture and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cap_q   <= 16'h0000;
            guess_q <= 16'h0000;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            guess_q <= guess_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign guess_out   = guess_q;
    assign guess_valid = valid_q;
    assign error       = error_q;

endmodule

// File: tb/tb_bc_guess_entry.sv
// tb/tb_bc_guess_entry.sv - self-checking bench for bc_guess_entry
module tb_bc_guess_entry;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] guess_out;
    logic        guess_valid;
    logic        guess_ready;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc, first_valid, n_valid, err_rise;
    logic [15:0] out_at_valid;
    logic prev_err, err_before;
    logic [15:0] model_out;
    logic model_err;

    bc_guess_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock),
        .reset(reset),
        .sw(sw),
        .btn(btn),
        .guess_out(guess_out),
        .guess_valid(guess_valid),
        .guess_ready(guess_ready),
        .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_valid(input logic [15:0] w);
        bit seen [10];
        int d;
        for (int i = 0; i < 10; i++) seen[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = int'((w >> (4 * i)) & 16'h000F);
            if (d > 9) return 1'b0;
            if (seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic clear_obs();
        cyc = 0;
        first_valid = 0;
        n_valid = 0;
        err_rise = 0;
        out_at_valid = 16'h0;
        prev_err = error;
        err_before = error;
    endtask

    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cyc++;
            if (guess_valid === 1'b1) begin
                n_valid++;
                if (first_valid == 0) begin
                    first_valid = cyc;
                    out_at_valid = guess_out;
                end
            end
            if (error === 1'b1 && prev_err !== 1'b1 && err_rise == 0) err_rise = cyc;
            prev_err = error;
        end
    endtask

    task automatic press(input logic [15:0] w, input int hold);
        sw = w;
        btn = 1'b1;
        clear_obs();
        observe(hold);
        btn = 1'b0;
        observe(D + 8);
    endtask

    task automatic check_press(input string tag, input logic [15:0] w);
        if (ref_valid(w)) begin
            chk({tag, " valid_latency"}, first_valid, D + 4);
            chk({tag, " valid_pulses"}, n_valid, 1);
            chk({tag, " guess_out_at_valid"}, out_at_valid, w);
            chk({tag, " error_clear"}, error, 0);
            model_out = w;
            model_err = 1'b0;
        end else begin
            chk({tag, " no_offer"}, n_valid, 0);
            chk({tag, " error_set"}, error, 1);
            if (err_before !== 1'b1) chk({tag, " error_latency"}, err_rise, D + 4);
            model_err = 1'b1;
        end
        chk({tag, " guess_out_hold"}, guess_out, model_out);
    endtask

    initial begin
        int digs [10];
        int j, tmp;
        logic [15:0] w;

        reset = 1'b0;
        btn = 1'b0;
        sw = 16'h0000;
        guess_ready = 1'b1;
        model_out = 16'h0000;
        model_err = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset guess_out", guess_out, 16'h0000);
        chk("reset guess_valid", guess_valid, 0);
        chk("reset error", error, 0);
        reset = 1'b1;
        repeat (D + 6) @(negedge clock);

        press(16'h1234, 12);
        check_press("t1_1234", 16'h1234);

        press(16'h1123, 12);
        check_press("t2_1123", 16'h1123);
        press(16'h5678, 12);
        check_press("t2_5678", 16'h5678);

        press(16'h12A4, 12);
        check_press("t3_12A4", 16'h12A4);

        sw = 16'h4321;
        btn = 1'b0;
        clear_obs();
        for (int k = 0; k < 15; k++) begin
            btn = ~btn;
            observe(2);
        end
        btn = 1'b0;
        observe(D + 8);
        chk("t4 bounce no_offer", n_valid, 0);
        chk("t4 bounce error", error, model_err);
        chk("t4 bounce guess_out", guess_out, model_out);

        guess_ready = 1'b0;
        sw = 16'h9876;
        btn = 1'b1;
        clear_obs();
        observe(12);
        chk("t5 valid_latency", first_valid, D + 4);
        btn = 1'b0;
        observe(10);
        sw = 16'h0123;
        btn = 1'b1;
        observe(10);
        btn = 1'b0;
        observe(D + 8);
        chk("t5 held_valid", guess_valid, 1);
        chk("t5 held_guess_out", guess_out, 16'h9876);
        chk("t5 never_dropped", n_valid, cyc - first_valid + 1);
        chk("t5 error", error, 0);
        guess_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("t5 transfer_drop", guess_valid, 0);
        clear_obs();
        observe(20);
        chk("t5 no_second_offer", n_valid, 0);
        model_out = 16'h9876;
        model_err = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                for (int k = 0; k < 10; k++) digs[k] = k;
                for (int k = 9; k > 0; k--) begin
                    j = int'($urandom_range(k, 0));
                    tmp = digs[k];
                    digs[k] = digs[j];
                    digs[j] = tmp;
                end
                w = {4'(digs[3]), 4'(digs[2]), 4'(digs[1]), 4'(digs[0])};
            end else begin
                w = 16'($urandom);
            end
            press(w, 12);
            check_press($sformatf("rand%0d_%04h", i, w), w);
        end

        guess_ready = 1'b0;
        sw = 16'h3847;
        btn = 1'b1;
        clear_obs();
        observe(12);
        chk("t6 offer_before_reset", guess_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 reset guess_valid", guess_valid, 0);
        chk("t6 reset guess_out", guess_out, 16'h0000);
        chk("t6 reset error", error, 0);
        @(negedge clock);
        reset = 1'b1;
        guess_ready = 1'b1;
        clear_obs();
        observe(30);
        chk("t6 held_btn no_offer", n_valid, 0);
        chk("t6 held_btn error", error, 0);
        model_out = 16'h0000;
        model_err = 1'b0;
        btn = 1'b0;
        observe(D + 8);
        press(16'h2468, 12);
        check_press("t6_repress", 16'h2468);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
